// File: rtl/ahb_slave_sram.sv
// AHB-Lite slave memory model: word-organised SRAM with byte/half/word
// access, programmable wait states and two-cycle ERROR on illegal access.
// Ports: hclk/hreset (async, active-high), AHB-Lite slave address/data
// inputs (hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready),
// slave response outputs (hreadyout, hresp, hrdata).
module ahb_slave_sram #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int WAIT_CYC  = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [3:0] CNT_INIT =
    4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_act;
  logic              r_write;
  logic [2:0]        r_size;
  logic [AW+1:0]     r_addr;
  logic              r_hready;
  logic              r_hresp;
  logic [DATA_W-1:0] r_rdata;

  logic              w_acc;
  logic              w_misal;
  logic              w_oor;
  logic              w_ill;
  logic              w_commit;
  logic [AW-1:0]     w_idx;
  logic [AW-1:0]     w_ridx;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_fwd;
  logic              w_unused;

  assign w_unused = ^{hburst, htrans[0]};

  assign w_acc   = hsel & hready & htrans[1];
  assign w_misal = (hsize == 3'd1 && haddr[0]) ||
                   (hsize == 3'd2 && haddr[1:0] != 2'b00);
  assign w_oor   = |haddr[ADDR_W-1:AW+2];
  assign w_ill   = (hsize > 3'd2) | w_misal | w_oor;

  assign w_idx  = haddr[AW+1:2];
  assign w_ridx = r_addr[AW+1:2];

  // A held write completes in the first ready cycle back in IDLE.
  assign w_commit = r_act & r_write & (r_state == S_IDLE);

  always_comb begin
    w_be = 4'b0000;
    case (r_size)
      3'd0:    w_be = 4'b0001 << r_addr[1:0];
      3'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    w_merged = r_mem[w_ridx];
    for (int k = 0; k < 4; k++) begin
      if (w_be[k]) w_merged[8*k +: 8] = hwdata[8*k +: 8];
    end
  end

  // Zero-wait read following a write to the same word sees the new word.
  assign w_fwd = (w_commit && w_ridx == w_idx) ? w_merged
                                                : r_mem[w_idx];

  always_ff @(posedge hclk) begin
    if (w_commit) r_mem[w_ridx] <= w_merged;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_act    <= 1'b0;
      r_write  <= 1'b0;
      r_size   <= 3'd0;
      r_addr   <= '0;
      r_hready <= 1'b1;
      r_hresp  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      unique case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state  <= S_IDLE;
            r_hready <= 1'b1;
            if (!r_write) r_rdata <= r_mem[w_ridx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
        end
        default: begin
          r_act    <= 1'b0;
          r_state  <= S_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= 1'b0;
          if (w_acc) begin
            r_addr  <= haddr[AW+1:0];
            r_write <= hwrite;
            r_size  <= hsize;
            if (w_ill) begin
              r_state  <= S_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= 1'b1;
            end else begin
              r_act <= 1'b1;
              if (WAIT_CYC == 0) begin
                if (!hwrite) r_rdata <= w_fwd;
              end else begin
                r_state  <= S_WAIT;
                r_cnt    <= CNT_INIT;
                r_hready <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  assign hreadyout = r_hready;
  assign hresp     = r_hresp;
  assign hrdata    = r_rdata;

endmodule

// File: tb/tb_ahb_slave_sram.sv
// Self-checking bench for ahb_slave_sram: three instances with 0, 2 and 3
// wait states, directed cases plus random traffic against a byte model.
module tb_ahb_slave_sram;

  localparam int ND = 3;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        bsel;
  logic        frc;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  int          cur;

  logic        hsel_a      [ND];
  logic        hready_a    [ND];
  logic        hreadyout_a [ND];
  logic        hresp_a     [ND];
  logic [31:0] hrdata_a    [ND];

  always #5 hclk = ~hclk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    assign hsel_a[g]   = bsel && (cur == g);
    assign hready_a[g] = hreadyout_a[g] & ~frc;
    ahb_slave_sram #(
      .WAIT_CYC ((g == 0) ? 0 : g + 1)
    ) u_dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .hsel      (hsel_a[g]),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hburst    (hburst),
      .hwdata    (hwdata),
      .hready    (hready_a[g]),
      .hreadyout (hreadyout_a[g]),
      .hresp     (hresp_a[g]),
      .hrdata    (hrdata_a[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl [int];
  logic [31:0] last_rd [ND];
  bit          p_vld;
  bit          p_wr;
  bit          p_ill;
  logic [31:0] p_addr;
  logic [31:0] p_wd;
  logic [2:0]  p_size;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d got=%h exp=%h", tag, cur, got, exp);
    end
  endtask

  function automatic int waits(input int d);
    return (d == 0) ? 0 : d + 1;
  endfunction

  function automatic bit illegal(input logic [31:0] a,
                                 input logic [2:0] s);
    if (s > 3'd2) return 1'b1;
    if ((a % (32'd1 << s)) != 0) return 1'b1;
    return a >= 32'd4096;
  endfunction

  function automatic int key(input logic [31:0] a);
    return cur * 4096 + int'(a >> 2);
  endfunction

  function automatic logic [31:0] rd_mdl(input logic [31:0] a);
    if (mdl.exists(key(a))) return mdl[key(a)];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic commit(input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] wd);
    logic [31:0] w;
    int b;
    w = rd_mdl(a);
    for (int i = 0; i < (1 << s); i++) begin
      b = int'(a % 4) + i;
      w[8*b +: 8] = wd[8*b +: 8];
    end
    mdl[key(a)] = w;
  endtask

  // One address phase; the previous transfer's data phase runs alongside.
  task automatic beat(input bit sel, input logic [1:0] tr, input bit wr,
                      input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd);
    int  wc;
    bit  done;
    wc     = 0;
    done   = 1'b0;
    bsel   = sel;
    htrans = tr;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
    hwdata = p_wd;
    while (!done) begin
      @(negedge hclk);
      chk("hresp", 32'(hresp_a[cur]), 32'(p_vld && p_ill));
      if (hreadyout_a[cur]) begin
        chk("waits", 32'(wc),
            32'(p_vld ? (p_ill ? 1 : waits(cur)) : 0));
        if (p_vld && !p_ill && !p_wr) last_rd[cur] = rd_mdl(p_addr);
        chk("hrdata", hrdata_a[cur], last_rd[cur]);
        @(posedge hclk);
        if (p_vld && !p_ill && p_wr) commit(p_addr, p_size, p_wd);
        p_vld  = sel && tr[1];
        p_wr   = wr;
        p_addr = a;
        p_size = sz;
        p_wd   = wd;
        p_ill  = illegal(a, sz);
        #1;
        done = 1'b1;
      end else begin
        chk("hrdata_hold", hrdata_a[cur], last_rd[cur]);
        wc++;
        if (wc > 20) begin
          chk("timeout", 32'(wc), 32'd20);
          done  = 1'b1;
          p_vld = 1'b0;
        end
        @(posedge hclk);
        #1;
      end
    end
  endtask

  task automatic idle();
    beat(1'b0, 2'd0, 1'b0, 32'd0, 3'd0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] s,
                    input logic [31:0] d);
    beat(1'b1, 2'd2, 1'b1, a, s, d);
  endtask

  task automatic rd(input logic [31:0] a);
    beat(1'b1, 2'd2, 1'b0, a, 3'd2, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  s;
    logic [1:0]  tr;
    hreset = 1'b1;
    frc    = 1'b0;
    bsel   = 1'b0;
    htrans = 2'd0;
    hwrite = 1'b0;
    haddr  = 32'd0;
    hsize  = 3'd0;
    hburst = 3'd0;
    hwdata = 32'd0;
    cur    = 0;
    p_vld  = 1'b0;
    p_wd   = 32'd0;
    for (int d = 0; d < ND; d++) last_rd[d] = 32'd0;

    repeat (2) @(posedge hclk);
    @(negedge hclk);
    for (int d = 0; d < ND; d++) begin
      cur = d;
      chk("rst_ready", 32'(hreadyout_a[d]), 32'd1);
      chk("rst_resp", 32'(hresp_a[d]), 32'd0);
      chk("rst_rdata", hrdata_a[d], 32'd0);
    end
    hreset = 1'b0;
    @(posedge hclk);
    #1;

    for (int d = 0; d < ND; d++) begin
      cur = d;
      for (int w = 0; w < 32; w++) wr(32'(w * 4), 3'd2, $urandom);
      idle();
    end

    cur = 0;
    wr(32'h10, 3'd2, 32'hDEADBEEF);
    rd(32'h10);
    idle();
    chk("fwd_word", hrdata_a[0], 32'hDEADBEEF);

    cur = 1;
    rd(32'h20);
    rd(32'h24);
    idle();

    cur = 0;
    wr(32'h40, 3'd2, 32'h0000_0000);
    wr(32'h41, 3'd0, 32'h0000_AA00);
    wr(32'h42, 3'd1, 32'h1234_0000);
    rd(32'h40);
    idle();
    chk("merge", hrdata_a[0], 32'h1234AA00);

    for (int d = 0; d < 2; d++) begin
      cur = d;
      rd(32'h04);
      wr(32'h06, 3'd2, 32'hBAD0_BAD0);
      wr(32'h1000, 3'd2, 32'hBAD1_BAD1);
      beat(1'b1, 2'd2, 1'b0, 32'h1004, 3'd2, 32'd0);
      wr(32'h08, 3'd3, 32'hBAD2_BAD2);
      rd(32'h04);
      rd(32'h00);
      rd(32'h08);
      idle();
    end

    cur = 0;
    beat(1'b1, 2'd1, 1'b1, 32'h10, 3'd2, 32'h1111_1111);
    beat(1'b1, 2'd0, 1'b1, 32'h10, 3'd2, 32'h2222_2222);
    rd(32'h10);
    idle();

    cur    = 1;
    frc    = 1'b1;
    bsel   = 1'b1;
    htrans = 2'd2;
    hwrite = 1'b1;
    haddr  = 32'h30;
    hsize  = 3'd2;
    hwdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge hclk);
      chk("noacc_ready", 32'(hreadyout_a[1]), 32'd1);
      @(posedge hclk);
      #1;
    end
    frc  = 1'b0;
    bsel = 1'b0;
    htrans = 2'd0;
    rd(32'h30);
    idle();

    for (int d = 0; d < ND; d++) begin
      cur = d;
      for (int n = 0; n < 300; n++) begin
        s  = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, 127));
        if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
        if ($urandom_range(0, 15) == 0) a = a + 32'h1000;
        tr = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) tr = 2'd2;
        beat($urandom_range(0, 7) != 0, tr, 1'($urandom), a, s, $urandom);
      end
      idle();
    end

    cur    = 2;
    bsel   = 1'b1;
    htrans = 2'd2;
    hwrite = 1'b1;
    haddr  = 32'h50;
    hsize  = 3'd2;
    @(posedge hclk);
    #1;
    bsel   = 1'b0;
    htrans = 2'd0;
    hwdata = 32'h5555_AAAA;
    @(negedge hclk);
    chk("rst_in_wait", 32'(hreadyout_a[2]), 32'd0);
    hreset = 1'b1;
    #1;
    chk("arst_ready", 32'(hreadyout_a[2]), 32'd1);
    chk("arst_resp", 32'(hresp_a[2]), 32'd0);
    chk("arst_rdata", hrdata_a[2], 32'd0);
    @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    for (int d = 0; d < ND; d++) last_rd[d] = 32'd0;
    p_vld = 1'b0;
    p_wd  = 32'd0;
    @(posedge hclk);
    #1;
    rd(32'h50);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/ahb_slave_sram.md
Name: ahb_slave_sram

Overview:
- AHB-Lite slave memory model attached to one slave port of the AHB interconnect DUT; consumes the transfers the interconnect routes to that port.
- Stores word-organised data and supports byte, halfword and word accesses.
- Inserts a programmable number of wait states and returns a two-cycle ERROR for illegal accesses.
- Instantiated once per slave port so interconnect checks run against real slave timing, not an idealised responder.

Parameters:
- DATA_W, 32, data bus width; only 32 supported.
- ADDR_W, 32, HADDR width.
- MEM_DEPTH, 1024, number of 32-bit words; power of two.
- WAIT_CYC, 0, wait states inserted in every OKAY data phase (0..15).

Ports:
- hclk  in  1  bus clock; all state updates on rising edge.
- hreset  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select from interconnect decoder.
- haddr  in  ADDR_W  byte address, local to this slave window.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1 = write.
- hsize  in  3  0 = byte, 1 = half, 2 = word; others illegal.
- hburst  in  3  ignored; each beat is treated independently.
- hwdata  in  DATA_W  write data, valid in the data phase.
- hready  in  1  bus-wide ready; qualifies address-phase sampling.
- hreadyout  out  1  this slave's ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  DATA_W  read data, valid when hreadyout=1 in a read data phase.

Behaviour:
- Reset: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, pending transfer cleared. Memory contents are not reset.
- Reset asserted mid-transfer: FSM goes to IDLE immediately; any pending write is dropped with no memory update.
- Accept condition: hsel & hready & htrans[1]. On accept, register haddr, hwrite and hsize into the data-phase holding registers.
- IDLE/BUSY, or hsel=0 with hready=1: no access, zero-wait OKAY on the next cycle.
- Illegal transfer, checked at accept:
  - hsize>2;
  - misaligned access (half with haddr[0]=1; word with haddr[1:0]!=0);
  - out of range: any bit of haddr[ADDR_W-1 : log2(MEM_DEPTH)+2] set.
  - Illegal writes never modify memory.
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE:
  - On a legal accept with WAIT_CYC>0: go to WAIT with counter=WAIT_CYC-1; hreadyout=0, hresp=0.
  - On a legal accept with WAIT_CYC=0: stay in IDLE and complete the data phase in the next cycle with hreadyout=1.
  - On an illegal accept: go to ERR1.
- WAIT: hreadyout=0. The counter decrements each cycle. At counter=0, the next cycle has hreadyout=1 (final data-phase cycle) and the FSM returns to IDLE or takes a new accept.
- ERR1: hreadyout=0, hresp=1. Always goes to ERR2.
- ERR2: hreadyout=1, hresp=1. A new accept is legal here; it is evaluated exactly as in IDLE.
- A new transfer is never accepted while hreadyout=0; hready is low then, which keeps the address phase held.
- Write commit: on the rising edge ending the final data-phase cycle (hreadyout=1), hwdata lanes are merged into the memory word at haddr[log2(MEM_DEPTH)+1:2].
  - Byte lane k is enabled for bytes at offset k, little-endian.
  - Half at offset 2 uses lanes 3:2.
- Read: hrdata holds the full 32-bit word (all lanes) in every cycle where hreadyout=1 for a read. In WAIT cycles and after writes, hrdata holds its previous value.
- Write-to-read hazard: when a read's address phase coincides with the final data cycle of a write to the same word, the read returns the merged post-write word. Forwarding is required; WAIT_CYC=0 must not return stale data.
- Back-to-back zero-wait transfers sustain one transfer per cycle.

Test Plan:
- WAIT_CYC=0: write word 0xDEADBEEF @0x10, then read @0x10 in the immediately following address phase -> hreadyout stays 1 throughout; read data phase hrdata=0xDEADBEEF, hresp=0 (forwarding path).
- WAIT_CYC=2: read @0x20 -> hreadyout=0 for exactly 2 cycles, 1 in the 3rd cycle with hrdata equal to stored word; next NONSEQ accepted on that edge.
- Byte write 0xAA @0x41, half write 0x1234 @0x42 over stored 0x00000000 @0x40 -> read @0x40 returns 0x1234AA00.
- Word access @0x06, then access @ byte address MEM_DEPTH*4 -> each gives hreadyout=0/hresp=1, then hreadyout=1/hresp=1; memory unchanged on readback.
- hsel=1 with htrans=BUSY, then htrans=IDLE -> hreadyout=1, hresp=0, no memory change; then hready=0 with NONSEQ -> not accepted.
- WAIT_CYC=3 write in WAIT state, assert hreset for one cycle -> hreadyout=1, hresp=0, hrdata=0 asynchronously; target word retains old value.
